// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multiply unit: FSM state encoding, the MIPS
// funct codes of the HI/LO instructions and the default datapath width.
// Optional feature macro used by the multiply unit: MULT_MFHI_EN.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_RUN,
    MULT_DONE
  } mult_state_t;

endpackage

// File: rtl/mult_shift_add_core.sv
// -----------------------------------------------------------------------------
// mult_shift_add_core
// Unsigned shift-and-add datapath for the iterative multiplier. Holds the
// operand magnitudes, the 2*WIDTH accumulator and the iteration counter.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   load       latch operand magnitudes, clear accumulator, load counter
//   step       perform one shift-and-add iteration
//   a_mag      multiplicand magnitude (unsigned)
//   b_mag      multiplier magnitude (unsigned)
//   count_zero counter has reached zero (this is the last iteration)
//   acc        accumulator value including the current cycle's partial product
// -----------------------------------------------------------------------------
module mult_shift_add_core
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic               count_zero,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // Exposing the post-step value lets the top capture the finished product
  // on the same edge as the final iteration.
  assign acc        = (step && mplier[0]) ? (acc_q + mcand) : acc_q;
  assign count_zero = (count == '0);

  // The multiplicand walks left while the multiplier walks right, so the
  // multiplier LSB always selects the correctly aligned partial product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc_q  <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      count  <= CW'(WIDTH - 1);
    end else if (step) begin
      acc_q  <= acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
// Iterative signed WIDTH x WIDTH multiplier with architectural HI/LO
// registers. Stalls the pipeline while a multiply is in flight and supplies
// LO (or HI) read data to write-back.
//
// Optional feature macro: MULT_MFHI_EN
//   defined   : HI register kept, mfhi_flag selects HI onto hilo_rd
//   undefined : HI not stored, mfhi_flag ignored, hi_out tied to 0
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   mult_operation decoder strobe, level, held with the instruction
//   mflo_flag      mflo requested
//   mfhi_flag      mfhi requested (only with MULT_MFHI_EN)
//   srcA, srcB     two's complement operands (rs, rt)
//   stall          freeze PC/instruction this cycle
//   busy           multiply in progress (registered)
//   done           one-cycle pulse, HI/LO just updated
//   hilo_rd        LO (or HI) read data
//   hi_out, lo_out HI and LO registers, debug
// -----------------------------------------------------------------------------
module mult_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_operation,
  input  logic             mflo_flag,
  input  logic             mfhi_flag,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hilo_rd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  mult_state_t        state;
  logic               armed;
  logic               sign;
  logic               start;
  logic               count_zero;
  logic               mfhi_sel;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_MFHI_EN
  logic [WIDTH-1:0] hi_q;
  assign mfhi_sel = mfhi_flag;
  assign hi_out   = hi_q;
`else
  logic unused_hi;
  assign mfhi_sel  = 1'b0;
  assign hi_out    = '0;
  assign unused_hi = ^{mfhi_flag, product[2*WIDTH-1:WIDTH]};
`endif

  // armed gating makes a held mult instruction launch only one multiply.
  assign start = mult_operation & armed & (state == MULT_IDLE);

  // Negating the most negative value wraps back onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign a_mag = srcA[WIDTH-1] ? -srcA : srcA;
  assign b_mag = srcB[WIDTH-1] ? -srcB : srcB;

  assign product = sign ? -acc : acc;

  // The read-request term only matters mid-multiply; in DONE the result is
  // already in the registers so no interlock is needed.
  assign stall = reset & (start | (state == MULT_RUN) |
                 ((mflo_flag | mfhi_sel) & (state != MULT_IDLE) & (state != MULT_DONE)));

  assign lo_out  = lo_q;
  assign hilo_rd = mfhi_sel ? hi_out : lo_q;

  mult_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .step      (state == MULT_RUN),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .count_zero(count_zero),
    .acc       (acc)
  );

  // Control FSM plus the architectural HI/LO registers and arming flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MULT_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      armed <= 1'b1;
      sign  <= 1'b0;
      lo_q  <= '0;
`ifdef MULT_MFHI_EN
      hi_q  <= '0;
`endif
    end else begin
      if (start) begin
        armed <= 1'b0;
      end else if (!mult_operation) begin
        armed <= 1'b1;
      end

      case (state)
        MULT_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= MULT_RUN;
            busy  <= 1'b1;
            sign  <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
          end
        end
        MULT_RUN: begin
          if (count_zero) begin
            state <= MULT_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            lo_q  <= product[WIDTH-1:0];
`ifdef MULT_MFHI_EN
            hi_q  <= product[2*WIDTH-1:WIDTH];
`endif
          end
        end
        MULT_DONE: begin
          state <= MULT_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MULT_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_unit
// Self-checking bench for mult_unit. Expected HI/LO pairs are queued when a
// multiply is issued; a monitor pops and compares them on every done pulse.
// Honours MULT_MFHI_EN when computing expected HI and mfhi read data.
// -----------------------------------------------------------------------------
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_operation;
  logic        mflo_flag;
  logic        mfhi_flag;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hilo_rd;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_item;

  mult_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mult_operation(mult_operation),
    .mflo_flag     (mflo_flag),
    .mfhi_flag     (mfhi_flag),
    .srcA          (srcA),
    .srcB          (srcB),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .hilo_rd       (hilo_rd),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // HI is only architecturally visible when the mfhi feature is built in.
  function automatic logic [63:0] expect_hilo(input logic [31:0] hi, input logic [31:0] lo);
`ifdef MULT_MFHI_EN
    return {hi, lo};
`else
    return {32'h0, lo};
`endif
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check_output("lo_out", {32'h0, lo_out}, {32'h0, exp_item[31:0]});
        check_output("hi_out", {32'h0, hi_out}, {32'h0, exp_item[63:32]});
      end
    end
  end

  // Issue one multiply with mult_operation held, count stalled cycles and
  // optionally raise mflo_flag mflo_at cycles after start.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ehi, input logic [31:0] elo,
                                input int mflo_at);
    int stalls;
    bit seen;
    stalls = 0;
    seen   = 1'b0;
    @(posedge clk);
    #1;
    srcA = a;
    srcB = b;
    exp_q.push_back(expect_hilo(ehi, elo));
    mult_operation = 1'b1;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        seen = 1'b1;
        check_output("stall_in_done", {63'h0, stall}, 64'd0);
        if (mflo_at >= 0) check_output("mflo_read_in_done", {32'h0, hilo_rd}, {32'h0, elo});
      end else if (cyc == mflo_at) begin
        mflo_flag = 1'b1;
      end
    end
    check_output("done_seen", {63'h0, seen}, 64'd1);
    check_output("stall_cycles", 64'(stalls), 64'd33);
    repeat (3) begin
      @(negedge clk);
      check_output("no_restart_while_held", {61'h0, busy, stall, done}, 64'd0);
    end
    mult_operation = 1'b0;
    mflo_flag      = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    mult_operation = 1'b1;
    mflo_flag      = 1'b0;
    mfhi_flag      = 1'b0;
    srcA           = 32'd7;
    srcB           = 32'd6;

    // Reset state; mult_operation high must not raise stall during reset.
    #12;
    check_output("rst_stall", {63'h0, stall}, 64'd0);
    check_output("rst_busy", {63'h0, busy}, 64'd0);
    check_output("rst_done", {63'h0, done}, 64'd0);
    check_output("rst_hi", {32'h0, hi_out}, 64'd0);
    check_output("rst_lo", {32'h0, lo_out}, 64'd0);
    check_output("rst_hilo_rd", {32'h0, hilo_rd}, 64'd0);
    mult_operation = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    apply_stimulus(32'd7,        32'd6,        32'h0000_0000, 32'd42,        -1);
    apply_stimulus(32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
    apply_stimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, -1);
    apply_stimulus(32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 3);

    // Reset asserted at RUN cycle 10 discards the in-flight product.
    @(posedge clk);
    #1;
    srcA = 32'd9;
    srcB = 32'd9;
    mult_operation = 1'b1;
    repeat (11) @(negedge clk);
    check_output("busy_before_reset", {63'h0, busy}, 64'd1);
    reset = 1'b0;
    mult_operation = 1'b0;
    #1;
    check_output("midrst_stall", {63'h0, stall}, 64'd0);
    check_output("midrst_busy", {63'h0, busy}, 64'd0);
    check_output("midrst_lo", {32'h0, lo_out}, 64'd0);
    check_output("midrst_hi", {32'h0, hi_out}, 64'd0);
    check_output("midrst_hilo_rd", {32'h0, hilo_rd}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    apply_stimulus(32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, -1);
    apply_stimulus(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, -1);

    // Read selection in IDLE: mfhi returns HI only when the feature exists.
    @(posedge clk);
    #1;
    mfhi_flag = 1'b1;
    @(negedge clk);
`ifdef MULT_MFHI_EN
    check_output("mfhi_rd", {32'h0, hilo_rd}, 64'd1);
`else
    check_output("mfhi_rd", {32'h0, hilo_rd}, 64'd0);
`endif
    check_output("mfhi_stall", {63'h0, stall}, 64'd0);
    mfhi_flag = 1'b0;
    mflo_flag = 1'b1;
    @(negedge clk);
    check_output("mflo_idle_rd", {32'h0, hilo_rd}, 64'd0);
    check_output("mflo_idle_stall", {63'h0, stall}, 64'd0);
    mflo_flag = 1'b0;

    repeat (2) @(negedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative signed 32x32 multiplier with architectural HI/LO registers. It sits directly downstream of the instruction decoder and consumes its `mult_operation` and `mflo_flag` strobes plus the register-file `srcA`/`srcB` operands. It drives a `stall` line to the PC/pipeline control while a multiply is in flight. It supplies `hilo_rd` to the write-back mux for `mflo` (and optionally `mfhi`).

## Interface
- `WIDTH`, 32, operand width; product is `2*WIDTH`; iteration count equals `WIDTH`
- `clk` input 1 system clock, rising edge
- `reset` input 1 asynchronous, active-low reset
- `mult_operation` input 1 decoder strobe, level, held while the instruction is held
- `mflo_flag` input 1 decoder strobe, mflo requested
- `mfhi_flag` input 1 mfhi requested (used only with `MULT_MFHI_EN`)
- `srcA` input WIDTH multiplicand, rs, two's complement
- `srcB` input WIDTH multiplier, rt, two's complement
- `stall` output 1 freeze PC/instruction this cycle
- `busy` output 1 multiply in progress (registered)
- `done` output 1 one-cycle pulse, HI/LO just updated
- `hilo_rd` output WIDTH LO (or HI) read data to write-back
- `hi_out` output WIDTH HI register, debug
- `lo_out` output WIDTH LO register, debug

## Operation
- **FSM states**
  - IDLE → RUN on `start`.
  - RUN → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally after 1 cycle.
- **Start condition:** `start = mult_operation & armed & (state==IDLE)`.
  - `armed` clears on `start`.
  - `armed` sets in any cycle with `mult_operation==0`.
  - A held `mult_operation` therefore launches exactly one multiply.
- **On start:**
  - Latch `|srcA|` and `|srcB|` as WIDTH-bit unsigned values. `0x80000000` stays `0x80000000`.
  - Latch `sign = srcA[W-1]^srcB[W-1]`.
  - Clear the 2W accumulator.
  - Load counter = WIDTH-1.
- **RUN, each cycle:** if multiplier LSB is 1, add multiplicand (shifted to current position) to the accumulator; shift multiplier right by 1; decrement counter.
- **Entering DONE:** `{HI,LO}` = sign ? −acc : acc (2W-bit two's complement). `done` asserts for the DONE cycle.
- **Stall:** `stall = start | (state==RUN) | ((mflo_flag|mfhi_flag) & state!=IDLE & state!=DONE)`.
  - `mflo`/`mfhi` issued during a multiply interlocks until the result exists.
  - `stall` is low in DONE, so the held mult instruction retires that cycle.
- **Read path:** `hilo_rd = mfhi_flag ? HI : LO`, combinational from the registers.
- **Simultaneous strobes:** `mult_operation` and `mflo_flag` high together: mult has priority; the mflo read is ignored for stall purposes.
- **Reset, including mid-RUN:**
  - Counter and accumulator clear; state = IDLE.
  - HI = LO = 0; `armed` = 1.
  - The in-flight product is discarded.
- **Reset values:** `busy=0`, `done=0`, `hi_out=0`, `lo_out=0`, `hilo_rd=0`. `stall` is forced 0 while `reset` is low.

## Timing
- Edge 0: `start` seen. `stall=1` combinationally in that cycle; operands are latched.
- Edges 1..WIDTH: RUN; `busy=1`, `stall=1`.
- The cycle after edge WIDTH is DONE: `busy=0`, `done=1`, `stall=0`, HI/LO valid.
- Total = WIDTH+1 stalled cycles (33 for WIDTH=32).
- HI/LO are unchanged outside the DONE transition.
- A new multiply needs `mult_operation` low for ≥1 cycle. Earliest re-start is 1 cycle after DONE.

## Configuration
- `MULT_MFHI_EN` defined:
  - HI register implemented.
  - `mfhi_flag` selects HI onto `hilo_rd`.
  - `hi_out` is live.
- Not defined:
  - HI is not stored; upper product bits are discarded.
  - `mfhi_flag` is ignored (treated 0).
  - `hi_out` is tied 0.
  - LO is still the exact low word of the signed product.

## Structure
- **Package `mips_pkg`:**
  - State enum `MULT_IDLE`/`MULT_RUN`/`MULT_DONE`.
  - Funct constants `FUNCT_MFHI=6'h10`, `FUNCT_MFLO=6'h12`, `FUNCT_MULT=6'h18`.
  - Default `WIDTH` constant.
- **Sub-module `mult_shift_add_core`:** operand latches, accumulator, shift and counter. It takes `load`/`step` and exposes `count_zero` and `acc`.
- **Top level `mult_unit`:** holds the FSM, `armed`, sign fix, HI/LO and stall logic.

## Test plan
- **Basic product:** `srcA=7`, `srcB=6`, `mult_operation` held high → `stall` high 33 cycles, then `done`. `LO=42`, `HI=0`. No second multiply while still held.
- **Negative times positive:** `srcA=0xFFFFFFFF`, `srcB=1` → `HI=0xFFFFFFFF`, `LO=0xFFFFFFFF`.
- **Extreme operands:** `srcA=srcB=0x80000000` → `HI=0x40000000`, `LO=0`. Without `MULT_MFHI_EN`: `LO=0`, `hi_out=0`.
- **Interlock:** `mflo_flag` asserted 3 cycles after `start` → `stall` held until DONE; `hilo_rd=LO` of the new product in DONE.
- **Reset mid-RUN:** `reset` pulsed low at RUN cycle 10 → IDLE, HI=LO=0, `stall=0`. Then `mult_operation` high → fresh 33-cycle multiply.
- **Mfhi select:** `mfhi_flag` in IDLE after `0x00010000*0x00010000` → `hilo_rd=1`, `stall=0`.
